// File: rtl/xorshift_chk_pkg.sv
// Shared types and the xorshift64 step used by the stream checker lanes.
package xorshift_chk_pkg;
  localparam int unsigned XS_W = 64;

  typedef enum logic [1:0] {S_SEED, S_RUN, S_DONE} lane_state_e;

  function automatic logic [XS_W-1:0] xorshift64_next(logic [XS_W-1:0] x);
    logic [XS_W-1:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction
endpackage

// File: rtl/xorshift_chk_lane.sv
// One lane: seed/run/done FSM, expected word, txn and saturating error counters.
// XORSHIFT_CHK_FIRST_ERR_EN adds capture of the first mismatching pair.
module xorshift_chk_lane
  import xorshift_chk_pkg::*;
#(
  parameter int unsigned TXN_NB = 1024,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vld_i,
  input  logic [XS_W-1:0]  data_i,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             ovf_o
`ifdef XORSHIFT_CHK_FIRST_ERR_EN
  ,
  output logic [XS_W-1:0]  first_exp_o,
  output logic [XS_W-1:0]  first_got_o
`endif
);

  localparam logic [CNT_W-1:0] TXN_LAST = CNT_W'(TXN_NB);

  lane_state_e      state_q, state_d;
  logic [XS_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0] txn_q, txn_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             mis;
  logic [XS_W-1:0]  nxt;

  assign nxt = xorshift64_next(data_i);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    txn_d   = txn_q;
    ecnt_d  = ecnt_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    mis     = 1'b0;
    if (vld_i) begin
      unique case (state_q)
        S_SEED: begin
          // A zero seed would lock xorshift at zero forever, so reject it.
          if (data_i == '0) begin
            mis = 1'b1;
          end else begin
            exp_d   = nxt;
            txn_d   = CNT_W'(1);
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          txn_d = txn_q + CNT_W'(1);
          mis   = (data_i != exp_q);
          exp_d = nxt;
          if (txn_d == TXN_LAST) state_d = S_DONE;
        end
        S_DONE:  ovf_d = 1'b1;
        default: state_d = S_SEED;
      endcase
    end
    if (mis) begin
      err_d = 1'b1;
      if (ecnt_q != '1) ecnt_d = ecnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SEED;
      exp_q   <= '0;
      txn_q   <= '0;
      ecnt_q  <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      txn_q   <= txn_d;
      ecnt_q  <= ecnt_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end

  assign done_o    = (state_q == S_DONE);
  assign err_o     = err_q;
  assign err_cnt_o = ecnt_q;
  assign ovf_o     = ovf_q;

`ifdef XORSHIFT_CHK_FIRST_ERR_EN
  logic [XS_W-1:0] fexp_q, fexp_d;
  logic [XS_W-1:0] fgot_q, fgot_d;

  always_comb begin
    fexp_d = fexp_q;
    fgot_d = fgot_q;
    if (mis && !err_q) begin
      fexp_d = (state_q == S_SEED) ? '0 : exp_q;
      fgot_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fexp_q <= '0;
      fgot_q <= '0;
    end else begin
      fexp_q <= fexp_d;
      fgot_q <= fgot_d;
    end
  end

  assign first_exp_o = fexp_q;
  assign first_got_o = fgot_q;
`endif

endmodule

// File: rtl/xorshift_stream_checker.sv
// Per-CPU xorshift64 stream checker: one lane instance per CPU plus all-done reduction.
// XORSHIFT_CHK_FIRST_ERR_EN adds first_exp_o/first_got_o mismatch capture ports.
module xorshift_stream_checker
  import xorshift_chk_pkg::*;
#(
  parameter int unsigned CPU_NB = 4,
  parameter int unsigned TXN_NB = 1024,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CPU_NB-1:0]       data_vld_i,
  input  logic [CPU_NB*XS_W-1:0]  data_i,
  output logic [CPU_NB-1:0]       done_o,
  output logic                    all_done_o,
  output logic [CPU_NB-1:0]       err_o,
  output logic [CPU_NB*CNT_W-1:0] err_cnt_o,
  output logic [CPU_NB-1:0]       ovf_o
`ifdef XORSHIFT_CHK_FIRST_ERR_EN
  ,
  output logic [CPU_NB*XS_W-1:0]  first_exp_o,
  output logic [CPU_NB*XS_W-1:0]  first_got_o
`endif
);

  for (genvar k = 0; k < CPU_NB; k++) begin : g_lane
    xorshift_chk_lane #(
      .TXN_NB (TXN_NB),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .vld_i       (data_vld_i[k]),
      .data_i      (data_i[k*XS_W +: XS_W]),
      .done_o      (done_o[k]),
      .err_o       (err_o[k]),
      .err_cnt_o   (err_cnt_o[k*CNT_W +: CNT_W]),
      .ovf_o       (ovf_o[k])
`ifdef XORSHIFT_CHK_FIRST_ERR_EN
      ,
      .first_exp_o (first_exp_o[k*XS_W +: XS_W]),
      .first_got_o (first_got_o[k*XS_W +: XS_W])
`endif
    );
  end

  // Combinational so it rises in the same cycle as the last lane's done.
  assign all_done_o = &done_o;

endmodule

// File: tb/tb_xorshift_stream_checker.sv
// Randomized self-checking bench for xorshift_stream_checker against a per-lane stream model.
module tb_xorshift_stream_checker;
  localparam int CPU_NB = 4;
  localparam int TXN_NB = 4;
  localparam int CNT_W  = 3;
  localparam int SAT    = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [CPU_NB-1:0]       data_vld_i = '0;
  logic [CPU_NB*64-1:0]    data_i = '0;
  logic [CPU_NB-1:0]       done_o;
  logic                    all_done_o;
  logic [CPU_NB-1:0]       err_o;
  logic [CPU_NB*CNT_W-1:0] err_cnt_o;
  logic [CPU_NB-1:0]       ovf_o;
  logic [CPU_NB*64-1:0]    first_exp_o;
  logic [CPU_NB*64-1:0]    first_got_o;

  xorshift_stream_checker #(.CPU_NB(CPU_NB), .TXN_NB(TXN_NB), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_vld_i  (data_vld_i),
    .data_i      (data_i),
    .done_o      (done_o),
    .all_done_o  (all_done_o),
    .err_o       (err_o),
    .err_cnt_o   (err_cnt_o),
    .ovf_o       (ovf_o)
`ifdef XORSHIFT_CHK_FIRST_ERR_EN
    ,
    .first_exp_o (first_exp_o),
    .first_got_o (first_got_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Reference model: words accepted per lane, next expected word, flags.
  int          m_cnt  [CPU_NB];
  logic [63:0] m_exp  [CPU_NB];
  bit          m_err  [CPU_NB];
  bit          m_ovf  [CPU_NB];
  int          m_ecnt [CPU_NB];
  logic [63:0] m_fexp [CPU_NB];
  logic [63:0] m_fgot [CPU_NB];

  function automatic logic [63:0] nx(logic [63:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < CPU_NB; k++) begin
      m_cnt[k] = 0; m_exp[k] = '0; m_err[k] = 0; m_ovf[k] = 0;
      m_ecnt[k] = 0; m_fexp[k] = '0; m_fgot[k] = '0;
    end
  endtask

  task automatic m_flag(input int k, input logic [63:0] e, input logic [63:0] g);
    if (!m_err[k]) begin m_fexp[k] = e; m_fgot[k] = g; end
    m_err[k] = 1;
    if (m_ecnt[k] < SAT) m_ecnt[k]++;
  endtask

  task automatic m_apply(input int k, input logic [63:0] w);
    if (m_cnt[k] >= TXN_NB) m_ovf[k] = 1;
    else if (m_cnt[k] == 0) begin
      if (w == 0) m_flag(k, 64'h0, 64'h0);
      else begin m_exp[k] = nx(w); m_cnt[k] = 1; end
    end else begin
      if (w != m_exp[k]) m_flag(k, m_exp[k], w);
      m_exp[k] = nx(w);
      m_cnt[k]++;
    end
  endtask

  task automatic check_all();
    logic [CPU_NB-1:0]       e_done, e_err, e_ovf;
    logic [CPU_NB*CNT_W-1:0] e_ecnt;
    logic [CPU_NB*64-1:0]    e_fexp, e_fgot;
    for (int k = 0; k < CPU_NB; k++) begin
      e_done[k] = (m_cnt[k] >= TXN_NB);
      e_err[k]  = m_err[k];
      e_ovf[k]  = m_ovf[k];
      e_ecnt[k*CNT_W +: CNT_W] = CNT_W'(m_ecnt[k]);
      e_fexp[k*64 +: 64] = m_fexp[k];
      e_fgot[k*64 +: 64] = m_fgot[k];
    end
    chk("done",     done_o,     e_done);
    chk("all_done", all_done_o, &e_done);
    chk("err",      err_o,      e_err);
    chk("err_cnt",  err_cnt_o,  e_ecnt);
    chk("ovf",      ovf_o,      e_ovf);
`ifdef XORSHIFT_CHK_FIRST_ERR_EN
    chk("first_exp", first_exp_o, e_fexp);
    chk("first_got", first_got_o, e_fgot);
`endif
  endtask

  // Present words on the lanes in v for one clock, then check 1 ns after the edge.
  task automatic step(input logic [CPU_NB-1:0] v, input logic [CPU_NB-1:0][63:0] w);
    data_vld_i = v;
    data_i     = w;
    @(posedge clk);
    for (int k = 0; k < CPU_NB; k++) if (v[k]) m_apply(k, w[k]);
    #1;
    data_vld_i = '0;
    data_i     = {CPU_NB*2{$urandom}};
    check_all();
  endtask

  task automatic one(input int k, input logic [63:0] word);
    logic [CPU_NB-1:0]       v;
    logic [CPU_NB-1:0][63:0] w;
    v = '0; w = {CPU_NB*2{$urandom}};
    v[k] = 1'b1; w[k] = word;
    step(v, w);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CPU_NB-1:0]       v;
    logic [CPU_NB-1:0][63:0] w;
    logic [63:0]             x;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst_n = 1'b1;

    // Lane 0: clean stream from seed 1; done one cycle after the 4th word.
    chk("next_of_1", nx(64'h1), 64'h4082_2041);
    x = 64'h1;
    for (int i = 0; i < TXN_NB; i++) begin one(0, x); x = nx(x); end

    // Lane 1: mismatch then resync on the received word.
    one(1, 64'h1);
    one(1, 64'hDEAD);
    one(1, nx(64'hDEAD));

    // Lane 2: zero seed rejected, then a real seed.
    one(2, 64'h0);
    one(2, 64'h1);

    // Lane 3: repeated zero seeds drive err_cnt into saturation.
    for (int i = 0; i < SAT + 2; i++) one(3, 64'h0);

    // Random traffic with gaps and occasional corruption; lane 3 only after 1 and 2 finish.
    for (int c = 0; c < 400 && !(m_cnt[3] >= TXN_NB); c++) begin
      v = '0; w = {CPU_NB*2{$urandom}};
      for (int k = 1; k < CPU_NB; k++) begin
        if (k == 3 && !(m_cnt[1] >= TXN_NB && m_cnt[2] >= TXN_NB)) continue;
        if (m_cnt[k] < TXN_NB && $urandom_range(0, 2) != 0) begin
          v[k] = 1'b1;
          if (m_cnt[k] == 0) w[k] = {$urandom, $urandom} | 64'h1;
          else if ($urandom_range(0, 7) == 0) w[k] = m_exp[k] ^ 64'h10;
          else w[k] = m_exp[k];
        end
      end
      step(v, w);
    end
    chk("all_done_final", all_done_o, 1'b1);

    // Word after done on lane 0 sets ovf only.
    one(0, {$urandom, $urandom});

    // Async reset mid-stream, then a fresh seed must be accepted cleanly.
    pulse_reset();
    x = {$urandom, $urandom} | 64'h1;
    for (int i = 0; i < 2; i++) begin one(0, x); x = nx(x); end
    pulse_reset();
    one(0, 64'h5);
    one(0, nx(64'h5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
